// File: rtl/ram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port RAM
// with a registered read port. The arbiter takes the slave view. The
// requesters and the RAM (or a testbench standing in for them) take the
// master view.
interface ram_arbiter_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
);
    logic                     req0_valid;
    logic                     req0_we;
    logic [ADDRESS_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0]    req0_wdata;
    logic                     req0_ready;
    logic                     req0_rvalid;
    logic [DATA_WIDTH-1:0]    req0_rdata;
    logic                     req0_err;

    logic                     req1_valid;
    logic                     req1_we;
    logic [ADDRESS_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0]    req1_wdata;
    logic                     req1_ready;
    logic                     req1_rvalid;
    logic [DATA_WIDTH-1:0]    req1_rdata;
    logic                     req1_err;

    logic                     ram_wEn;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_dataIn;
    logic [DATA_WIDTH-1:0]    ram_dataOut;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata, req0_err,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata, req1_err,
        output ram_wEn, ram_addr, ram_dataIn,
        input  ram_dataOut
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata, req0_err,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata, req1_err,
        input  ram_wEn, ram_addr, ram_dataIn,
        output ram_dataOut
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a registered
// read port. A grant is combinational, so a lone requester sees no added
// latency. Read data returns one cycle after acceptance and is steered by
// a registered owner flag. Writes into the device-owned input window
// IO_IN_LO..IO_IN_HI are dropped and answered with a one-cycle err pulse.
// Optional feature: define RAM_ARBITER_ROUND_ROBIN_EN for round-robin tie
// breaking through last_grant. Without the macro, requester 0 always wins
// ties.
module ram_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int IO_IN_LO      = 4086,
    parameter int IO_IN_HI      = 4090
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    localparam logic [ADDRESS_WIDTH-1:0] IO_LO = ADDRESS_WIDTH'(IO_IN_LO);
    localparam logic [ADDRESS_WIDTH-1:0] IO_HI = ADDRESS_WIDTH'(IO_IN_HI);

    function automatic logic in_io_window(input logic [ADDRESS_WIDTH-1:0] a);
        return (a >= IO_LO) && (a <= IO_HI);
    endfunction

    logic                     gnt0, gnt1, gnt_any;
    logic                     sel_we, io_hit;
    logic [ADDRESS_WIDTH-1:0] sel_addr, addr_hold;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic [DATA_WIDTH-1:0]    rdata0_hold, rdata1_hold;
    logic                     rd_vld_p1, rd_own_p1;
    logic                     err0_p1, err1_p1;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    logic                     last_grant;
`endif

    // Grant decision. Nothing is granted while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
                gnt0 = last_grant;
                gnt1 = !last_grant;
`else
                gnt0 = 1'b1;
`endif
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    // Route the granted request onto the RAM side.
    always_comb begin
        gnt_any   = gnt0 | gnt1;
        sel_we    = gnt1 ? bus.req1_we    : bus.req0_we;
        sel_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
        io_hit    = in_io_window(sel_addr);
    end

    assign bus.req0_ready  = gnt0;
    assign bus.req1_ready  = gnt1;
    assign bus.ram_wEn     = gnt_any & sel_we & ~io_hit;
    assign bus.ram_addr    = gnt_any ? sel_addr : addr_hold;
    assign bus.ram_dataIn  = sel_wdata;

    assign bus.req0_rvalid = rd_vld_p1 & ~rd_own_p1;
    assign bus.req1_rvalid = rd_vld_p1 &  rd_own_p1;
    assign bus.req0_rdata  = bus.req0_rvalid ? bus.ram_dataOut : rdata0_hold;
    assign bus.req1_rdata  = bus.req1_rvalid ? bus.ram_dataOut : rdata1_hold;
    assign bus.req0_err    = err0_p1;
    assign bus.req1_err    = err1_p1;

    // Response stage: read-return flag, owner, and rejected-write pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p1 <= 1'b0;
            rd_own_p1 <= 1'b0;
            err0_p1   <= 1'b0;
            err1_p1   <= 1'b0;
        end else begin
            rd_vld_p1 <= gnt_any & ~sel_we;
            rd_own_p1 <= gnt1;
            err0_p1   <= gnt0 & sel_we & io_hit;
            err1_p1   <= gnt1 & sel_we & io_hit;
        end
    end

    // Keep the last granted address on the RAM bus while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold <= '0;
        end else if (gnt_any) begin
            addr_hold <= sel_addr;
        end
    end

    // Latch returned read data so rdata stays stable between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_hold <= '0;
            rdata1_hold <= '0;
        end else begin
            if (bus.req0_rvalid) rdata0_hold <= bus.ram_dataOut;
            if (bus.req1_rvalid) rdata1_hold <= bus.ram_dataOut;
        end
    end

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    // Round-robin pointer. It moves only on an accepted transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt_any) begin
            last_grant <= gnt1;
        end
    end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter. A behavioural RAM with a registered read port
// sits behind the arbiter. Stimulus pushes each expected response
// (read data or err pulse) into a queue. A negedge monitor pops and
// compares whatever the DUT presents.
module tb_ram_arbiter;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   cyc    = 0;
    int   ntests = 0;
    int   nerr   = 0;

    ram_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(12)) bus ();

    ram_arbiter #(
        .DATA_WIDTH(32), .ADDRESS_WIDTH(12), .IO_IN_LO(4086), .IO_IN_HI(4090)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read, write on ram_wEn.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.ram_wEn) mem[bus.ram_addr] <= bus.ram_dataIn;
        bus.ram_dataOut <= mem[bus.ram_addr];
    end

    typedef struct {
        int          who;
        bit          is_err;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int who, input bit is_err, input logic [31:0] d);
        exp_t e;
        e.who    = who;
        e.is_err = is_err;
        e.data   = d;
        e.due    = cyc + 1;
        q.push_back(e);
    endtask

    task automatic set_req(input int id, input logic v, input logic we,
                           input logic [11:0] a, input logic [31:0] d);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every response slot against the scoreboard.
    always @(negedge clk) begin
        logic [3:0] obs, want;
        exp_t e;
        if (rst_n) begin
            obs = {bus.req0_rvalid, bus.req1_rvalid, bus.req0_err, bus.req1_err};
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                ntests++;
                nerr++;
                $display("FAIL resp_missing: got nothing expected who=%0d err=%0d data=%0h due %0d",
                         e.who, e.is_err, e.data, e.due);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                if (e.is_err) want = (e.who == 0) ? 4'b0010 : 4'b0001;
                else          want = (e.who == 0) ? 4'b1000 : 4'b0100;
                check("resp_flags", 64'(obs), 64'(want));
                if (!e.is_err)
                    check("resp_rdata", 64'((e.who == 0) ? bus.req0_rdata : bus.req1_rdata), 64'(e.data));
            end else begin
                check("no_resp", 64'(obs), 64'(0));
            end
        end
    end

    logic [3:0] s2_gnt1;
    logic       g1;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[10]   = 32'h1111_0010;
        mem[20]   = 32'h2222_0020;
        mem[4088] = 32'hA5A5_A5A5;
        mem[4089] = 32'h0000_0003;
        mem[4090] = 32'h0000_4090;
        s2_gnt1 = RR ? 4'b1010 : 4'b0000;

        // Reset state with requests pending
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 12'd5, 32'h0);
        set_req(1, 1'b1, 1'b0, 12'd6, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_ready0", 64'(bus.req0_ready), 64'(0));
        check("rst_ready1", 64'(bus.req1_ready), 64'(0));
        check("rst_wen",    64'(bus.ram_wEn), 64'(0));
        check("rst_addr",   64'(bus.ram_addr), 64'(0));
        check("rst_rvalid", 64'({bus.req0_rvalid, bus.req1_rvalid}), 64'(0));
        check("rst_err",    64'({bus.req0_err, bus.req1_err}), 64'(0));
        check("rst_rdata0", 64'(bus.req0_rdata), 64'(0));
        check("rst_rdata1", 64'(bus.req1_rdata), 64'(0));

        // Scenario 2: both read from the first cycle out of reset
        next_cycle();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 12'd10, 32'h0);
        set_req(1, 1'b1, 1'b0, 12'd20, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) next_cycle();
            @(negedge clk);
            g1 = s2_gnt1[i];
            check("s2_ready0", 64'(bus.req0_ready), 64'(!g1));
            check("s2_ready1", 64'(bus.req1_ready), 64'(g1));
            check("s2_addr",   64'(bus.ram_addr), g1 ? 64'd20 : 64'd10);
            push(g1 ? 1 : 0, 1'b0, g1 ? 32'h2222_0020 : 32'h1111_0010);
        end

        // Scenario 1: write then read back
        next_cycle();
        set_req(1, 1'b0, 1'b0, 12'd0, 32'h0);
        set_req(0, 1'b1, 1'b1, 12'd100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("s1_ready0", 64'(bus.req0_ready), 64'(1));
        check("s1_wen",    64'(bus.ram_wEn), 64'(1));
        check("s1_addr",   64'(bus.ram_addr), 64'd100);
        check("s1_din",    64'(bus.ram_dataIn), 64'hDEAD_BEEF);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 12'd100, 32'h0);
        @(negedge clk);
        check("s1_rd_wen", 64'(bus.ram_wEn), 64'(0));
        push(0, 1'b0, 32'hDEAD_BEEF);

        // Scenario 6: idle slot between reads
        next_cycle();
        set_req(0, 1'b0, 1'b0, 12'd0, 32'h0);
        @(negedge clk);
        check("s6_idle_ready", 64'(bus.req0_ready), 64'(0));
        check("s6_idle_wen",   64'(bus.ram_wEn), 64'(0));
        check("s6_addr_hold",  64'(bus.ram_addr), 64'd100);
        next_cycle();
        set_req(0, 1'b1, 1'b0, 12'd10, 32'h0);
        @(negedge clk);
        check("s6_gap_rvalid", 64'(bus.req0_rvalid), 64'(0));
        check("s6_rdata_hold", 64'(bus.req0_rdata), 64'hDEAD_BEEF);
        push(0, 1'b0, 32'h1111_0010);

        // Scenario 3: writes around the input window from requester 1
        next_cycle();
        set_req(0, 1'b0, 1'b0, 12'd0, 32'h0);
        set_req(1, 1'b1, 1'b1, 12'd4088, 32'd5);
        @(negedge clk);
        check("s3_ready1", 64'(bus.req1_ready), 64'(1));
        check("s3_ready0", 64'(bus.req0_ready), 64'(0));
        check("s3_wen_4088", 64'(bus.ram_wEn), 64'(0));
        push(1, 1'b1, 32'h0);
        next_cycle();
        set_req(1, 1'b1, 1'b1, 12'd4090, 32'd9);
        @(negedge clk);
        check("s3_wen_4090", 64'(bus.ram_wEn), 64'(0));
        push(1, 1'b1, 32'h0);
        next_cycle();
        set_req(1, 1'b1, 1'b1, 12'd4091, 32'd8);
        @(negedge clk);
        check("s3_wen_4091", 64'(bus.ram_wEn), 64'(1));
        next_cycle();
        set_req(1, 1'b1, 1'b1, 12'd4095, 32'd7);
        @(negedge clk);
        check("s3_wen_4095", 64'(bus.ram_wEn), 64'(1));
        next_cycle();
        set_req(1, 1'b1, 1'b0, 12'd4088, 32'h0);
        @(negedge clk);
        push(1, 1'b0, 32'hA5A5_A5A5);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 12'd4095, 32'h0);
        @(negedge clk);
        push(1, 1'b0, 32'd7);
        next_cycle();
        set_req(1, 1'b1, 1'b0, 12'd4090, 32'h0);
        @(negedge clk);
        push(1, 1'b0, 32'h0000_4090);

        // Scenario 4: read inside the window is allowed
        next_cycle();
        set_req(1, 1'b0, 1'b0, 12'd0, 32'h0);
        set_req(0, 1'b1, 1'b0, 12'd4089, 32'h0);
        @(negedge clk);
        push(0, 1'b0, 32'h3);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 12'd0, 32'h0);
        @(negedge clk);
        check("s4_no_err", 64'(bus.req0_err), 64'(0));

        // Scenario 5: reset asserted mid-cycle while read data is returning
        next_cycle();
        set_req(0, 1'b1, 1'b0, 12'd10, 32'h0);
        @(negedge clk);
        check("s5_ready0", 64'(bus.req0_ready), 64'(1));
        @(posedge clk);
        #1;
        set_req(1, 1'b1, 1'b0, 12'd20, 32'h0);
        check("s5_rvalid_pre", 64'(bus.req0_rvalid), 64'(1));
        check("s5_rdata_pre",  64'(bus.req0_rdata), 64'h1111_0010);
        #1;
        rst_n = 1'b0;
        #1;
        check("s5_rvalid_rst", 64'(bus.req0_rvalid), 64'(0));
        check("s5_rdata_rst",  64'(bus.req0_rdata), 64'(0));
        check("s5_ready_rst",  64'({bus.req0_ready, bus.req1_ready}), 64'(0));
        check("s5_addr_rst",   64'(bus.ram_addr), 64'(0));
        check("s5_wen_rst",    64'(bus.ram_wEn), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("s5_tie_ready0", 64'(bus.req0_ready), 64'(1));
        check("s5_tie_ready1", 64'(bus.req1_ready), 64'(0));
        push(0, 1'b0, 32'h1111_0010);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 12'd0, 32'h0);
        set_req(1, 1'b0, 1'b0, 12'd0, 32'h0);
        next_cycle();
        @(negedge clk);
        check("s5_quiet", 64'({bus.req0_rvalid, bus.req1_rvalid}), 64'(0));

        repeat (3) next_cycle();
        check("sb_drained", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", ntests, nerr);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data bus width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 12, meaning the word address width.
REQ-003 The block SHALL have parameter IO_IN_LO, default 4086, meaning the lowest device-owned input register address.
REQ-004 The block SHALL have parameter IO_IN_HI, default 4090, meaning the highest device-owned input register address.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port reqN_valid, input, 1 bit, for N=0,1: request present.
REQ-008 The block SHALL have port reqN_we, input, 1 bit: 1=write, 0=read.
REQ-009 The block SHALL have port reqN_addr, input, ADDRESS_WIDTH bits: word address.
REQ-010 The block SHALL have port reqN_wdata, input, DATA_WIDTH bits: write data.
REQ-011 The block SHALL have port reqN_ready, output, 1 bit: request accepted this cycle.
REQ-012 The block SHALL have port reqN_rvalid, output, 1 bit: read data valid.
REQ-013 The block SHALL have port reqN_rdata, output, DATA_WIDTH bits: read data.
REQ-014 The block SHALL have port reqN_err, output, 1 bit: one-cycle pulse for a rejected write.
REQ-015 The block SHALL have port ram_wEn, output, 1 bit: RAM write enable.
REQ-016 The block SHALL have port ram_addr, output, ADDRESS_WIDTH bits: RAM address.
REQ-017 The block SHALL have port ram_dataIn, output, DATA_WIDTH bits: RAM write data.
REQ-018 The block SHALL have port ram_dataOut, input, DATA_WIDTH bits: RAM registered read data, valid one cycle after the address is presented.

Function
REQ-019 The block SHALL accept a transfer when reqN_valid and reqN_ready are both high at a rising edge.
REQ-020 At most one reqN_ready SHALL be high per cycle, and it SHALL be combinational from the valids and the arbitration state.
REQ-021 When exactly one requester is valid, that requester SHALL be granted with zero added latency.
REQ-022 When both requesters are valid, the grant SHALL go to the requester not granted most recently (round-robin pointer last_grant).
REQ-023 last_grant SHALL update only on an accepted transfer.
REQ-024 The granted request SHALL drive ram_addr and ram_dataIn in the same cycle.
REQ-025 ram_wEn SHALL equal granted reqN_we, except that ram_wEn SHALL be 0 when the address lies within IO_IN_LO..IO_IN_HI inclusive.
REQ-026 An accepted write inside IO_IN_LO..IO_IN_HI SHALL be dropped, and reqN_err SHALL pulse high for exactly one cycle after acceptance.
REQ-027 An accepted read SHALL raise reqN_rvalid exactly one cycle after acceptance, with reqN_rdata = ram_dataOut in that cycle.
REQ-028 Reads SHALL be pipelined at one per cycle, with back-to-back reads from alternating requesters routed by a registered response-owner flag.
REQ-029 Reads of any address, including IO regions, SHALL be permitted.
REQ-030 With no grant, ram_wEn SHALL be 0, ram_addr SHALL hold its last value, and no rvalid SHALL be generated the next cycle.
REQ-031 Accepted writes SHALL produce no rvalid.
REQ-032 reqN_rdata SHALL hold its last value when rvalid is low.

Reset
REQ-033 While rst_n is low, all reqN_rvalid, reqN_err, reqN_ready and ram_wEn SHALL be 0, with rdata and ram_addr = 0 and last_grant = 1 (requester 0 wins the first tie).
REQ-034 A read accepted in the cycle reset asserts SHALL produce no rvalid after reset releases.
REQ-035 The first grant SHALL be possible in the first cycle with rst_n high.

Configuration
REQ-036 When macro RAM_ARBITER_ROUND_ROBIN_EN is defined, tie-breaking SHALL follow REQ-022.
REQ-037 When RAM_ARBITER_ROUND_ROBIN_EN is undefined, requester 0 SHALL always win ties (fixed priority), and last_grant SHALL be absent.

Verification
REQ-038 Scenario 1: req0 write addr 100 data 0xDEADBEEF, then a req0 read of 100 SHALL give ram_wEn=1 in cycle 1, and rvalid0 with rdata0=0xDEADBEEF one cycle after the read acceptance.
REQ-039 Scenario 2: both requesters hold valid reads for 4 cycles from reset SHALL give grants 0,1,0,1 and rvalid 0,1,0,1, each delayed one cycle (fixed priority: 0,0,0,0).
REQ-040 Scenario 3: a req1 write to 4088 with data 5 SHALL give ram_wEn=0, err1 pulsing for one cycle, and an unchanged RAM word; a write to 4095 with data 7 SHALL be performed.
REQ-041 Scenario 4: req0 read addr 4089 while RAM holds 0x3 SHALL give rvalid0 with rdata0=0x3 and no err.
REQ-042 Scenario 5: rst_n driven low mid-cycle during an accepted read SHALL drive outputs to 0 immediately, with no rvalid after release and the first tie granted to 0.
REQ-043 Scenario 6: an idle cycle between reads SHALL give rvalid low for exactly that slot.
